// File: rtl/jtag_dr_pkg.sv
// Shared widths and helpers for the JTAG user-DR bridge.
// JTAG_DR_PARITY_EN adds an odd-parity MSB to every frame.
package jtag_dr_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DEPTH  = 4;

  function automatic int frame_w(input int data_w, input int addr_w);
`ifdef JTAG_DR_PARITY_EN
    return data_w + addr_w + 1;
`else
    return data_w + addr_w;
`endif
  endfunction

  // Bit that makes the total number of ones (vec plus this bit) odd.
  function automatic logic odd_par(input logic [63:0] vec);
    return ~(^vec);
  endfunction

endpackage

// File: rtl/jtag_dr_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle.
module jtag_dr_fifo
  import jtag_dr_pkg::*;
#(
  parameter int W     = DEF_DATA_W + DEF_ADDR_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          tck,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic          full,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage is cleared so the head reads as zero out of reset.
  always_ff @(posedge tck) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/jtag_dr_bridge.sv
// JTAG user data-register bridge: shift/latch {data, addr} frames and queue
// them for the consumer. JTAG_DR_PARITY_EN enables the parity MSB and perr.
module jtag_dr_bridge
  import jtag_dr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic              tck,
  input  logic              reset,
  input  logic              tdi,
  output logic              tdo,
  input  logic              capture,
  input  logic              shift,
  input  logic              e1dr,
  input  logic              update,
  input  logic [DATA_W-1:0] cap_data,
  input  logic [ADDR_W-1:0] cap_addr,
  output logic [DATA_W-1:0] rx_data,
  output logic [ADDR_W-1:0] rx_addr,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [LW-1:0]     rx_level,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic              perr,
  output logic              upd_pulse
);

  localparam int PW = ADDR_W + DATA_W;
  localparam int FW = frame_w(DATA_W, ADDR_W);

  logic [FW-1:0] shreg, lat;
  logic [PW-1:0] head;
  logic          push_req, par_ok, fifo_push, fifo_pop, full, empty;

  assign tdo       = shreg[0];
  assign push_req  = update && !upd_pulse;
  assign fifo_push = push_req && par_ok;
  assign fifo_pop  = rx_valid && rx_ready;
  assign rx_valid  = !empty;
  assign rx_data   = head[PW-1:ADDR_W];
  assign rx_addr   = head[ADDR_W-1:0];

  always_ff @(posedge tck) begin
    if (reset) begin
      shreg     <= '0;
      lat       <= '0;
      upd_pulse <= 1'b0;
    end else begin
      if (shift)
        shreg <= {tdi, shreg[FW-1:1]};
      else if (capture)
`ifdef JTAG_DR_PARITY_EN
        shreg <= {ovf | perr, cap_data, cap_addr};
`else
        shreg <= {cap_data, cap_addr};
`endif
      if (e1dr) lat <= shreg;
      upd_pulse <= update;
    end
  end

  // A full FIFO with a concurrent pop still accepts the frame, so no overflow.
  always_ff @(posedge tck) begin
    if (reset)                                 ovf <= 1'b0;
    else if (fifo_push && full && !fifo_pop)   ovf <= 1'b1;
    else if (ovf_clr)                          ovf <= 1'b0;
  end

`ifdef JTAG_DR_PARITY_EN
  assign par_ok = (lat[FW-1] == odd_par(64'(lat[PW-1:0])));

  always_ff @(posedge tck) begin
    if (reset)                    perr <= 1'b0;
    else if (push_req && !par_ok) perr <= 1'b1;
    else if (ovf_clr)             perr <= 1'b0;
  end
`else
  assign par_ok = 1'b1;
  assign perr   = 1'b0;
`endif

  jtag_dr_fifo #(.W(PW), .DEPTH(DEPTH)) u_fifo (
    .tck   (tck),
    .reset (reset),
    .push  (fifo_push),
    .din   (lat[PW-1:0]),
    .pop   (fifo_pop),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .level (rx_level)
  );

endmodule

// File: tb/tb_jtag_dr_bridge.sv
// Directed bench for jtag_dr_bridge with default widths (8-bit data, 3-bit addr, depth 4).
module tb_jtag_dr_bridge;

`ifdef JTAG_DR_PARITY_EN
  localparam int FW = 12;
`else
  localparam int FW = 11;
`endif

  logic       tck = 1'b0;
  logic       reset = 1'b1;
  logic       tdi = 1'b0, tdo;
  logic       capture = 1'b0, shift = 1'b0, e1dr = 1'b0, update = 1'b0;
  logic [7:0] cap_data = '0;
  logic [2:0] cap_addr = '0;
  logic [7:0] rx_data;
  logic [2:0] rx_addr;
  logic       rx_valid, rx_ready = 1'b0;
  logic [2:0] rx_level;
  logic       ovf, ovf_clr = 1'b0, perr, upd_pulse;

  int checks = 0;
  int errors = 0;

  jtag_dr_bridge dut (
    .tck(tck), .reset(reset), .tdi(tdi), .tdo(tdo),
    .capture(capture), .shift(shift), .e1dr(e1dr), .update(update),
    .cap_data(cap_data), .cap_addr(cap_addr),
    .rx_data(rx_data), .rx_addr(rx_addr), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_level(rx_level), .ovf(ovf), .ovf_clr(ovf_clr), .perr(perr), .upd_pulse(upd_pulse)
  );

  always #5 tck = ~tck;

  typedef struct {
    logic [10:0] word;
    logic [2:0]  addr;
    logic [7:0]  data;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  function automatic logic [FW-1:0] good_frame(input logic [10:0] w);
`ifdef JTAG_DR_PARITY_EN
    return {~(^w), w};
`else
    return w;
`endif
  endfunction

  task automatic send_bits(input logic [FW-1:0] f, input logic pop_upd, input int upd_cycles);
    shift = 1'b1;
    for (int i = 0; i < FW; i++) begin
      tdi = f[i];
      tick();
    end
    shift = 1'b0;
    tdi   = 1'b0;
    e1dr  = 1'b1;
    tick();
    e1dr     = 1'b0;
    update   = 1'b1;
    rx_ready = pop_upd;
    tick();
    rx_ready = 1'b0;
    for (int i = 1; i < upd_cycles; i++) tick();
    update = 1'b0;
  endtask

  task automatic pop1();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic chk_head(input string nm, input logic [2:0] a, input logic [7:0] d);
    chk({nm, "_valid"}, 32'(rx_valid), 32'd1);
    chk({nm, "_addr"},  32'(rx_addr),  32'(a));
    chk({nm, "_data"},  32'(rx_data),  32'(d));
  endtask

  logic [FW-1:0] cap_exp;

  initial begin
    vecs[0] = '{word: 11'h5A3, addr: 3'h3, data: 8'hB4};
    vecs[1] = '{word: 11'h7FF, addr: 3'h7, data: 8'hFF};
    vecs[2] = '{word: 11'h001, addr: 3'h1, data: 8'h00};
    vecs[3] = '{word: 11'h400, addr: 3'h0, data: 8'h80};

    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", 32'(rx_valid),  32'd0);
    chk("rst_level", 32'(rx_level),  32'd0);
    chk("rst_ovf",   32'(ovf),       32'd0);
    chk("rst_perr",  32'(perr),      32'd0);
    chk("rst_tdo",   32'(tdo),       32'd0);
    chk("rst_upd",   32'(upd_pulse), 32'd0);
    chk("rst_data",  32'(rx_data),   32'd0);
    chk("rst_addr",  32'(rx_addr),   32'd0);

    for (int v = 0; v < 4; v++) begin
      send_bits(good_frame(vecs[v].word), 1'b0, 1);
      chk_head($sformatf("vec%0d", v), vecs[v].addr, vecs[v].data);
      chk($sformatf("vec%0d_level", v), 32'(rx_level), 32'd1);
      pop1();
      chk($sformatf("vec%0d_drain", v), 32'(rx_valid), 32'd0);
    end

    // update held for three cycles must push only once
    send_bits(good_frame(11'h5A3), 1'b0, 3);
    chk("hold_level", 32'(rx_level), 32'd1);
    pop1();
    chk("hold_drain", 32'(rx_level), 32'd0);
    pop1();
    chk("empty_pop_level", 32'(rx_level), 32'd0);

    cap_data = 8'hC3;
    cap_addr = 3'h5;
`ifdef JTAG_DR_PARITY_EN
    cap_exp = {1'b0, 11'h61D};
`else
    cap_exp = 11'h61D;
`endif
    capture = 1'b1;
    tick();
    capture = 1'b0;
    shift   = 1'b1;
    for (int i = 0; i < FW; i++) begin
      chk($sformatf("cap_tdo%0d", i), 32'(tdo), 32'(cap_exp[i]));
      tick();
    end
    shift = 1'b0;

    send_bits(good_frame({8'h11, 3'd1}), 1'b0, 1);
    send_bits(good_frame({8'h22, 3'd2}), 1'b0, 1);
    send_bits(good_frame({8'h33, 3'd3}), 1'b0, 1);
    send_bits(good_frame({8'h44, 3'd4}), 1'b0, 1);
    chk("full_level", 32'(rx_level), 32'd4);
    chk("full_ovf",   32'(ovf),      32'd0);
    send_bits(good_frame({8'h55, 3'd5}), 1'b0, 1);
    chk("ovf_level", 32'(rx_level), 32'd4);
    chk("ovf_set",   32'(ovf),      32'd1);
    chk_head("ovf_head", 3'd1, 8'h11);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);

    send_bits(good_frame({8'h66, 3'd6}), 1'b1, 1);
    chk("pp_level", 32'(rx_level), 32'd4);
    chk("pp_ovf",   32'(ovf),      32'd0);
    chk_head("pp_head", 3'd2, 8'h22);
    pop1();
    chk_head("drain1", 3'd3, 8'h33);
    pop1();
    chk_head("drain2", 3'd4, 8'h44);
    pop1();
    chk_head("drain3", 3'd6, 8'h66);
    pop1();
    chk("drain_empty", 32'(rx_valid), 32'd0);

    shift = 1'b1;
    tdi   = 1'b1;
    repeat (5) tick();
    shift  = 1'b0;
    tdi    = 1'b0;
    reset  = 1'b1;
    update = 1'b1;
    tick();
    reset  = 1'b0;
    update = 1'b0;
    tick();
    chk("midrst_valid", 32'(rx_valid),  32'd0);
    chk("midrst_level", 32'(rx_level),  32'd0);
    chk("midrst_shreg", 32'(dut.shreg), 32'd0);
    chk("midrst_tdo",   32'(tdo),       32'd0);

`ifdef JTAG_DR_PARITY_EN
    send_bits({^(11'h5A3), 11'h5A3}, 1'b0, 1);
    chk("par_valid", 32'(rx_valid), 32'd0);
    chk("par_perr",  32'(perr),     32'd1);
    capture = 1'b1;
    tick();
    capture = 1'b0;
    shift   = 1'b1;
    repeat (FW - 1) tick();
    shift = 1'b0;
    chk("par_msb", 32'(tdo), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("par_clr", 32'(perr), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_dr_bridge.md
# jtag_dr_bridge

Parametrised JTAG user data-register bridge: it sits between the `jtag_tap` primitive and on-chip debug logic such as the LM32 debug unit. Frames are `{data, addr}` with configurable widths. Completed Update-DR frames are buffered in a first-word-fall-through FIFO with a valid/ready handshake, so the consumer may stall without losing host writes. On Capture-DR, the host-visible word is loaded together with FIFO status.

## Interface
Parameters:
- `DATA_W`, 8: payload width in bits, at least 1.
- `ADDR_W`, 3: register address width in bits, at least 1.
- `DEPTH`, 4: receive FIFO entries; power of two, at least 2.

Ports:
- `tck` in 1: JTAG clock; all logic is on its rising edge.
- `reset` in 1: reset, synchronous, active-high. Driven by TAP test-logic-reset.
- `tdi` in 1: serial data from the TAP.
- `tdo` out 1: serial data to the TAP; equals `shreg[0]`.
- `capture`, `shift`, `e1dr`, `update` in 1 each: TAP DR state decodes.
- `cap_data` in DATA_W: payload returned to the host on capture.
- `cap_addr` in ADDR_W: address returned to the host on capture.
- `rx_data` out DATA_W: FIFO head payload.
- `rx_addr` out ADDR_W: FIFO head address.
- `rx_valid` out 1: FIFO not empty.
- `rx_ready` in 1: consumer pop request; a pop occurs when `rx_valid && rx_ready`.
- `rx_level` out $clog2(DEPTH+1): FIFO occupancy.
- `ovf` out 1: sticky flag; a frame was dropped because the FIFO was full.
- `ovf_clr` in 1: clears `ovf`.
- `perr` out 1: sticky flag for a parity error. Tied 0 when parity is compiled out.
- `upd_pulse` out 1: registered copy of `update`.

## Operation
Frame layout:
- Frame width `FW = ADDR_W + DATA_W` (plus 1 when parity is enabled).
- Bit 0 is the address LSB. The data LSB sits at bit `ADDR_W`. The optional parity bit is the MSB.

Shift register `shreg[FW-1:0]`:
- When `shift` is high: `shreg <= {tdi, shreg[FW-1:1]}`.
- Otherwise, when `capture` is high: `shreg <= {cap_data, cap_addr}`.
  - With parity enabled, the parity MSB carries the status bit `ovf | perr`, not parity.
- Priority: `shift` wins over `capture`. This case is illegal per the TAP and must not be asserted.

Latch `lat`: `lat <= shreg` when `e1dr` is high.

Push:
- On the first tck cycle with `update` high, the `{data, addr}` fields of `lat` are pushed.
- Back-to-back `update` cycles push once per rising edge of `update`, detected against `upd_pulse`.

FIFO rules:
- Push when full and no pop in the same cycle: frame dropped, `ovf <= 1`.
- Push and pop in the same cycle, including when full: both are performed and `rx_level` is unchanged.
- Pop when empty: ignored.
- Read and write pointers wrap modulo `DEPTH`.

Flags: `ovf_clr` clears `ovf` (and `perr`). A set event in the same cycle wins over the clear.

Reset values: `shreg`, `lat`, `rx_data`, `rx_addr`, `rx_valid`, `rx_level`, `ovf`, `perr` and `upd_pulse` are all 0. Pointers are 0. `tdo` is 0.

Reset mid-frame: partial shift contents are discarded and no push occurs.

## Timing
- `tdo` changes only after a tck rising edge.
- Update to consumer: with `update` high at edge N, `rx_valid` and the head data are visible after edge N. Latency is 1 cycle into an empty FIFO.
- Pop to next head: a pop at edge M presents the next head after edge M.
- `rx_level` and `ovf` are updated at the same edge as the push or pop that changes them.

## Configuration
`JTAG_DR_PARITY_EN`:
- Defined:
  - `FW` gains a MSB holding odd parity over `{data, addr}`, written by the host.
  - On push, a frame whose parity is wrong is dropped and `perr <= 1`.
  - On capture, the MSB carries the `ovf | perr` status bit.
- Undefined:
  - `FW = ADDR_W + DATA_W`, with no parity checking.
  - `perr` is constant 0.

## Structure
- Package `jtag_dr_pkg`:
  - function `frame_w(DATA_W, ADDR_W)`;
  - function `odd_par(vec)`;
  - localparam default widths.
- Sub-module `jtag_dr_fifo`, a synchronous FWFT FIFO:
  - parameters `W`, `DEPTH`;
  - ports `push`, `din`, `pop`, `dout`, `empty`, `full`, `level`.
- The top level holds the shift register, latch, push-edge detect and flags.

## Test plan
- Reset, then 11 shift cycles of `tdi` pattern 0x5A3 (LSB first), then e1dr, then update → `rx_valid=1`, `rx_addr=3'h3`, `rx_data=8'hB4`, `rx_level=1`.
- `cap_data=8'hC3`, `cap_addr=3'h5`, then capture and 11 shift cycles → `tdo` sequence LSB-first of 0x61D.
- Push 5 frames with `rx_ready=0` (DEPTH=4) → `rx_level=4`, `ovf=1`, head is frame 1. `ovf_clr` → `ovf=0`.
- FIFO full with `rx_ready=1` and a simultaneous push → no overflow, `rx_level` stays 4, head advances by one.
- Reset asserted after 5 shift cycles, then update → `rx_valid=0`, `shreg=0`.
- (`JTAG_DR_PARITY_EN` defined) frame with wrong parity → not pushed, `perr=1`; next capture shifts out MSB=1.
